// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a request/data_ok instruction memory port,
// tracks the next fetch PC, absorbs one returned instruction in a skid buffer
// while decode is stalled or flushed, and discards in-flight fetches made
// stale by a branch/jump resolved in decode. Feeds the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        pcSrcD,
   input  logic [31:0] pcBranchD,
   input  logic        jumpD,
   input  logic [31:0] pcJumpD,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_rdata,
   input  logic        inst_data_ok,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic [31:0] pcPlus4D,
   output logic        validD,
   output logic [5:0]  opD,
   output logic [5:0]  functD
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // Fetch bookkeeping
   logic [31:0] r_pcF;
   logic [31:0] w_pcF_nxt;
   logic [31:0] r_reqAddr;
   logic [31:0] w_reqAddr_nxt;

   // Skid buffer: one returned instruction parked while decode cannot accept it
   logic [31:0] r_skidInstr;
   logic [31:0] w_skidInstr_nxt;
   logic [31:0] r_skidPc;
   logic [31:0] w_skidPc_nxt;
   logic        r_skidValid;
   logic        w_skidValid_nxt;

   // IF/ID pipeline register
   logic [31:0] r_instrD;
   logic [31:0] r_pcD;
   logic [31:0] r_pcPlus4D;
   logic        r_validD;
   logic [31:0] w_instrD_nxt;
   logic [31:0] w_pcD_nxt;
   logic [31:0] w_pcPlus4D_nxt;
   logic        w_validD_nxt;

   // Instruction offered to IF/ID this cycle (from memory or skid buffer)
   logic        w_haveInstr;
   logic [31:0] w_newInstr;
   logic [31:0] w_newPc;

   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pcPlus4;
   logic        w_accept;

   // A redirect only counts when the branch/jump in decode is real and moving on
   assign w_redirect = (jumpD | pcSrcD) & r_validD & ~stallD & ~flushD;
   assign w_target   = (jumpD ? pcJumpD : pcBranchD) & ~32'd3;
   assign w_pcPlus4  = r_pcF + 32'd4;
   assign w_accept   = ~stallD & ~flushD;

   // Memory-side outputs depend only on registered state
   assign inst_req  = (r_state == S_WAIT) || (r_state == S_DISCARD);
   assign inst_addr = r_reqAddr;

   assign instrD   = r_instrD;
   assign pcD      = r_pcD;
   assign pcPlus4D = r_pcPlus4D;
   assign validD   = r_validD;
   assign opD      = r_instrD[31:26];
   assign functD   = r_instrD[5:0];

   // FSM state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, fetch address and skid buffer decisions
   always_comb begin
      w_state_nxt     = r_state;
      w_pcF_nxt       = r_pcF;
      w_reqAddr_nxt   = r_reqAddr;
      w_skidInstr_nxt = r_skidInstr;
      w_skidPc_nxt    = r_skidPc;
      w_skidValid_nxt = r_skidValid;
      w_haveInstr     = 1'b0;
      w_newInstr      = '0;
      w_newPc         = '0;

      case (r_state)
         S_IDLE: begin
            // Any data_ok seen here belongs to a request abandoned by reset
            w_reqAddr_nxt = r_pcF;
            w_state_nxt   = S_WAIT;
         end

         S_WAIT: begin
            if (w_redirect) begin
               w_pcF_nxt = w_target;
               if (inst_data_ok) begin
                  // Returned instruction is on the wrong path: drop it
                  w_reqAddr_nxt = w_target;
               end else begin
                  // Request must stay stable until it completes; its data is stale
                  w_state_nxt = S_DISCARD;
               end
            end else if (inst_data_ok) begin
               w_pcF_nxt     = w_pcPlus4;
               w_reqAddr_nxt = w_pcPlus4;
               if (w_accept) begin
                  w_haveInstr = 1'b1;
                  w_newInstr  = inst_rdata;
                  w_newPc     = r_reqAddr;
               end else begin
                  w_skidInstr_nxt = inst_rdata;
                  w_skidPc_nxt    = r_reqAddr;
                  w_skidValid_nxt = 1'b1;
                  w_state_nxt     = S_HOLD;
               end
            end
         end

         S_DISCARD: begin
            if (w_redirect) begin
               w_pcF_nxt = w_target;
            end
            if (inst_data_ok) begin
               w_reqAddr_nxt = w_redirect ? w_target : r_pcF;
               w_state_nxt   = S_WAIT;
            end
         end

         S_HOLD: begin
            if (w_redirect) begin
               // Parked instruction follows the branch: no delay slot, drop it
               w_pcF_nxt       = w_target;
               w_reqAddr_nxt   = w_target;
               w_skidValid_nxt = 1'b0;
               w_state_nxt     = S_WAIT;
            end else if (w_accept) begin
               w_haveInstr     = r_skidValid;
               w_newInstr      = r_skidInstr;
               w_newPc         = r_skidPc;
               w_skidValid_nxt = 1'b0;
               w_reqAddr_nxt   = r_pcF;
               w_state_nxt     = S_WAIT;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // IF/ID next value: flush beats stall; redirect or no instruction gives a bubble
   always_comb begin
      w_instrD_nxt   = r_instrD;
      w_pcD_nxt      = r_pcD;
      w_pcPlus4D_nxt = r_pcPlus4D;
      w_validD_nxt   = r_validD;
      if (flushD || (!stallD && (w_redirect || !w_haveInstr))) begin
         w_instrD_nxt   = '0;
         w_pcD_nxt      = '0;
         w_pcPlus4D_nxt = '0;
         w_validD_nxt   = 1'b0;
      end else if (!stallD) begin
         w_instrD_nxt   = w_newInstr;
         w_pcD_nxt      = w_newPc;
         w_pcPlus4D_nxt = w_newPc + 32'd4;
         w_validD_nxt   = 1'b1;
      end
   end

   // Fetch PC, request address and skid buffer registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_pcF       <= RESET_PC;
         r_reqAddr   <= RESET_PC;
         r_skidInstr <= '0;
         r_skidPc    <= '0;
         r_skidValid <= 1'b0;
      end else begin
         r_pcF       <= w_pcF_nxt;
         r_reqAddr   <= w_reqAddr_nxt;
         r_skidInstr <= w_skidInstr_nxt;
         r_skidPc    <= w_skidPc_nxt;
         r_skidValid <= w_skidValid_nxt;
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_instrD   <= '0;
         r_pcD      <= '0;
         r_pcPlus4D <= '0;
         r_validD   <= 1'b0;
      end else begin
         r_instrD   <= w_instrD_nxt;
         r_pcD      <= w_pcD_nxt;
         r_pcPlus4D <= w_pcPlus4D_nxt;
         r_validD   <= w_validD_nxt;
      end
   end

endmodule
